ovl_fire_collector: RTL
=======================

// Module: ovl_fire_collector
// PURPOSE
//  Downstream consumer of the checker fabric. Samples the per-checker fire bits (out) of NUM_CHK
//  ovl_combo checker slices plus the chain-end configInvalid. Captures each firing cycle into a
//  small show-ahead event FIFO, keeps sticky/count status and drives one interrupt line to the core.
// PARAMETERS
//  NUM_CHK     8   number of checker fire inputs
//  FIFO_DEPTH  4   event FIFO entries; power of 2, >= 2
//  CNT_WIDTH   8   width of saturating fire-event counter
//  TS_WIDTH    16  timestamp width (used only with OVL_FIRE_TIMESTAMP_EN)
// PORTS
//  clk               in   1          clock
//  rst               in   1          reset, synchronous, active-high
//  fire_i            in   NUM_CHK    fire bit from each checker slice
//  fire_valid_i      in   1          fabric enable; fire_i ignored when 0
//  config_invalid_i  in   1          configInvalid from end of checker chain
//  mask_i            in   NUM_CHK    1 = ignore that checker
//  clear_i           in   1          flush FIFO, clear sticky/count/overflow
//  rd_en_i           in   1          pop head entry
//  rd_valid_o        out  1          FIFO non-empty; rd_data_o valid
//  rd_data_o         out  NUM_CHK(+TS_WIDTH)  head entry {ts, fire_vec}
//  sticky_o          out  NUM_CHK    OR of all captured vectors since clear
//  fire_count_o      out  CNT_WIDTH  captured events, saturating
//  overflow_o        out  1          event dropped on full FIFO since clear
//  irq_o             out  1          interrupt request (registered)
// BEHAVIOUR
//  - Reset: every output 0, FIFO empty, FSM IDLE, timestamp 0.
//  - Capture cond: fire_valid_i & ~config_invalid_i & |(fire_i & ~mask_i). Vector stored = fire_i & ~mask_i.
//  - Latency: capture at edge N -> rd_valid_o/rd_data_o, sticky_o, fire_count_o updated after edge N (visible cycle N+1).
//  - FIFO show-ahead: rd_data_o = head whenever rd_valid_o. rd_en_i while empty: ignored.
//  - Full + capture + no pop: entry dropped, overflow_o set; count still increments.
//  - Full + capture + pop same cycle: pop and push both happen, no overflow.
//  - Empty + capture + rd_en_i: rd_en_i ignored, entry pushed.
//  - Pointers wrap modulo FIFO_DEPTH; occupancy counter log2(FIFO_DEPTH)+1 bits.
//  - fire_count_o saturates at 2^CNT_WIDTH-1; never wraps.
//  - config_invalid_i high: no capture, status held; FIFO pops still serviced.
//  - clear_i: highest priority; FIFO flushed, sticky/count/overflow zeroed, capture and pop that cycle discarded; FSM -> IDLE.
//  - rst mid-operation: same as reset state; in-flight entries lost.
//  - IRQ FSM (2-bit): IDLE irq=0; PEND irq=1; OVF irq=1.
//    IDLE->PEND on push; PEND->IDLE when last entry popped and no push; any->OVF on drop;
//    OVF exits only on clear_i (->IDLE). irq_o is a register output of the FSM state.
// CONFIGURATION
//  OVL_FIRE_TIMESTAMP_EN defined: free-running TS_WIDTH counter (wraps, reset 0) stored with each entry;
//    rd_data_o = {ts[TS_WIDTH-1:0], fire_vec}, ts = counter value at capture edge.
//  Not defined: no counter, rd_data_o = fire_vec only (NUM_CHK bits).
// STRUCTURE
//  - Shared include ovl_fabric_defines.v: IRQ FSM state encodings (IDLE=2'd0,PEND=2'd1,OVF=2'd2),
//    default NUM_CHK/CNT_WIDTH/TS_WIDTH, entry-width macro.
//  - One sub-module: ovl_event_fifo (parameterized width/depth, show-ahead, push/pop/flush, full/empty).
//  - Top: capture qualify, status regs, saturating counter, timestamp, IRQ FSM.
// TESTING
//  1 fire_i=8'h05, mask_i=0, valid=1, cfg_inv=0 at cycle 3 -> cycle 4 rd_valid=1, rd_data[7:0]=8'h05, sticky=8'h05, count=1, irq=1.
//  2 mask_i=8'h04, fire_i=8'h04 -> no capture, rd_valid stays 0; fire_i=8'h06 -> entry 8'h02.
//  3 5 consecutive captures, no pops (DEPTH=4) -> 4 entries, overflow=1, FSM OVF, count=5; pop 4 -> irq stays 1 until clear_i.
//  4 FIFO full, capture + rd_en same cycle -> occupancy stays 4, overflow=0, head advances.
//  5 config_invalid_i=1 with fire_i=8'hFF -> nothing captured; clear_i with simultaneous capture -> all status 0, FIFO empty.
//  6 OVL_FIRE_TIMESTAMP_EN: captures at timestamps 10 and 0xFFFF+2 -> rd_data ts fields 10, 1 (wrap).

Source files
------------

// File: rtl/ovl_fire_collector_pkg.sv
// Shared definitions for the checker-fire collector: IRQ FSM state encoding,
// default geometry and the FIFO entry-width helper.
// Optional feature macro: OVL_FIRE_TIMESTAMP_EN (adds a timestamp to each entry).
package ovl_fire_collector_pkg;

  localparam int DEF_NUM_CHK    = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_WIDTH  = 8;
  localparam int DEF_TS_WIDTH   = 16;

`ifdef OVL_FIRE_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  // IRQ FSM: IDLE (no irq), PEND (entries waiting), OVF (sticky until clear)
  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_PEND = 2'd1,
    IRQ_OVF  = 2'd2
  } irq_state_e;

  // Width of one event entry: fire vector, plus timestamp when enabled
  function automatic int entry_width(input int num_chk, input int ts_width);
    return num_chk + (TS_ON ? ts_width : 0);
  endfunction

endpackage

// File: rtl/ovl_event_fifo.sv
// Show-ahead event FIFO: head entry is presented on rd_data whenever not empty.
// Push on full (without pop) and pop on empty are ignored; flush empties it.
module ovl_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  // Storage write; contents need no reset since occupancy gates validity
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally (power-of-2 depth); occupancy tracks push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ovl_fire_collector.sv
// Collects checker fire bits into an event FIFO, keeps sticky/count/overflow
// status and raises a registered interrupt.
// Optional feature macro: OVL_FIRE_TIMESTAMP_EN (free-running timestamp stored per entry).
// Handshake: rd_valid_o means rd_data_o holds the head entry; asserting rd_en_i
// while rd_valid_o is high consumes it at the clock edge; rd_en_i while empty is ignored.
module ovl_fire_collector
  import ovl_fire_collector_pkg::*;
#(
  parameter int NUM_CHK    = DEF_NUM_CHK,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int TS_WIDTH   = DEF_TS_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_CHK-1:0]                        fire_i,
  input  logic                                      fire_valid_i,
  input  logic                                      config_invalid_i,
  input  logic [NUM_CHK-1:0]                        mask_i,
  input  logic                                      clear_i,
  input  logic                                      rd_en_i,
  output logic                                      rd_valid_o,
  output logic [entry_width(NUM_CHK, TS_WIDTH)-1:0] rd_data_o,
  output logic [NUM_CHK-1:0]                        sticky_o,
  output logic [CNT_WIDTH-1:0]                      fire_count_o,
  output logic                                      overflow_o,
  output logic                                      irq_o,
  output logic [1:0]                                irq_state_o
);

  localparam int EW = entry_width(NUM_CHK, TS_WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CHK-1:0] fire_vec;
  logic [EW-1:0]      entry;
  logic [EW-1:0]      head;
  logic               capture, push, pop, drop, last_pop;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count;
  irq_state_e         state_q, state_d;
  logic               irq_q;
  logic [NUM_CHK-1:0] sticky_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic               overflow_q;

  // A capture needs a live fabric, a valid chain and at least one unmasked fire
  assign fire_vec = fire_i & ~mask_i;
  assign capture  = fire_valid_i & ~config_invalid_i & (|fire_vec);
  assign pop      = rd_en_i & ~fifo_empty & ~clear_i;
  assign push     = capture & (~fifo_full | pop) & ~clear_i;
  assign drop     = capture & fifo_full & ~pop & ~clear_i;
  assign last_pop = pop & ~push & (fifo_count == CW'(1));

`ifdef OVL_FIRE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  // Free-running timestamp; only reset clears it, clear_i does not
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + TS_WIDTH'(1);
  end

  assign entry = {ts_q, fire_vec};
`else
  assign entry = fire_vec;
`endif

  ovl_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (clear_i),
    .push    (push),
    .pop     (pop),
    .wr_data (entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Sticky OR, saturating event count and overflow flag; clear_i wins
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      sticky_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (capture) begin
      sticky_q <= sticky_q | fire_vec;
      if (count_q != '1) count_q <= count_q + CNT_WIDTH'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // IRQ FSM state register with irq registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IRQ_IDLE;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= (state_d != IRQ_IDLE);
    end
  end

  // IRQ FSM next state: drop forces OVF, clear forces IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE: if (push)     state_d = IRQ_PEND;
      IRQ_PEND: if (last_pop) state_d = IRQ_IDLE;
      IRQ_OVF:                state_d = IRQ_OVF;
      default:                state_d = IRQ_IDLE;
    endcase
    if (drop)    state_d = IRQ_OVF;
    if (clear_i) state_d = IRQ_IDLE;
  end

  assign rd_valid_o   = ~fifo_empty;
  assign rd_data_o    = fifo_empty ? '0 : head;
  assign sticky_o     = sticky_q;
  assign fire_count_o = count_q;
  assign overflow_o   = overflow_q;
  assign irq_o        = irq_q;
  assign irq_state_o  = state_q;

endmodule
